// File: rtl/dispense_arbiter.sv
// dispense_arbiter
//   Round-robin arbiter and sequencer for the 4:1 product-select mux.
//   Picks one of four slot requesters, drives the mux select and a one-hot
//   grant, holds the grant for HOLD_CYCLES out_ready-qualified cycles, and
//   then acknowledges the winner with a one-cycle done pulse.
//
//   Parameters:
//     HOLD_CYCLES - number of ready-qualified cycles a grant is held
//                   (legal 1..2^CNT_W-1, 0 behaves as 1)
//     CNT_W       - width of the dispense counter
//
//   Ports:
//     clk        in   1  system clock, rising edge
//     rst_n      in   1  asynchronous active-low reset
//     req        in   4  per-slot dispense request (level)
//     out_ready  in   1  downstream ready, qualifies hold counting
//     sel        out  2  mux select, index of current/last winner
//     grant      out  4  one-hot grant, zero when idle
//     busy       out  1  high from selection through the release cycle
//     done       out  4  one-hot, one-cycle acknowledge to the winner
//
//   Build option:
//     ARB_FIXED_PRIO_EN - when defined, fixed priority replaces round-robin
//                         (req[0] highest); the rotating pointer is removed.
module dispense_arbiter #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       out_ready,
  output logic [1:0] sel,
  output logic [3:0] grant,
  output logic       busy,
  output logic [3:0] done
);

  // A hold of zero would never complete, so it is clamped to one cycle.
  localparam int               HOLD_EFF  = (HOLD_CYCLES < 1) ? 1 : HOLD_CYCLES;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_EFF - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPENSE = 2'd1,
    RELEASE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [1:0]       sel_nxt;
  logic [3:0]       grant_nxt;
  logic             busy_nxt;
  logic [3:0]       done_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       winner;

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    onehot = 4'b0001 << idx;
  endfunction

`ifdef ARB_FIXED_PRIO_EN
  // Lowest index wins; no rotation state is kept.
  function automatic logic [1:0] pick_fixed(input logic [3:0] r);
    logic [1:0] w;
    w = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (r[i]) w = 2'(i);
    end
    return w;
  endfunction

  assign winner = pick_fixed(req);
`else
  logic [1:0] ptr, ptr_nxt;

  // First set bit scanning ptr, ptr+1, ptr+2, ptr+3 (2-bit wrap gives mod 4).
  function automatic logic [1:0] pick_rr(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    logic [1:0] w;
    logic       found;
    w     = p;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = p + 2'(i);
      if (!found && r[idx]) begin
        w     = idx;
        found = 1'b1;
      end
    end
    return w;
  endfunction

  assign winner = pick_rr(req, ptr);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sel   <= 2'd0;
      grant <= 4'd0;
      busy  <= 1'b0;
      done  <= 4'd0;
      cnt   <= '0;
`ifndef ARB_FIXED_PRIO_EN
      ptr   <= 2'd0;
`endif
    end else begin
      state <= state_nxt;
      sel   <= sel_nxt;
      grant <= grant_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
      cnt   <= cnt_nxt;
`ifndef ARB_FIXED_PRIO_EN
      ptr   <= ptr_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    grant_nxt = grant;
    busy_nxt  = busy;
    done_nxt  = 4'd0;
    cnt_nxt   = cnt;
`ifndef ARB_FIXED_PRIO_EN
    ptr_nxt   = ptr;
`endif
    unique case (state)
      IDLE: begin
        grant_nxt = 4'd0;
        busy_nxt  = 1'b0;
        if (|req) begin
          sel_nxt   = winner;
          grant_nxt = onehot(winner);
          busy_nxt  = 1'b1;
          cnt_nxt   = '0;
          state_nxt = DISPENSE;
        end
      end
      DISPENSE: begin
        // A withdrawn winner aborts silently; this wins over completion.
        if (!req[sel]) begin
          grant_nxt = 4'd0;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
`ifndef ARB_FIXED_PRIO_EN
          ptr_nxt   = sel + 2'd1;
`endif
        end else if (out_ready) begin
          if (cnt == HOLD_LAST) begin
            grant_nxt = 4'd0;
            done_nxt  = onehot(sel);
            state_nxt = RELEASE;
`ifndef ARB_FIXED_PRIO_EN
            ptr_nxt   = sel + 2'd1;
`endif
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
      end
      RELEASE: begin
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
      default: begin
        grant_nxt = 4'd0;
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dispense_arbiter.sv
// tb_dispense_arbiter
//   Directed bench for dispense_arbiter with HOLD_CYCLES=4. Inputs change and
//   outputs are sampled 1 time unit after each rising edge.
module tb_dispense_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       out_ready;
  logic [1:0] sel;
  logic [3:0] grant;
  logic       busy;
  logic [3:0] done;

  int n_checks;
  int n_errors;

  dispense_arbiter #(
    .HOLD_CYCLES(4),
    .CNT_W      (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .out_ready(out_ready),
    .sel      (sel),
    .grant    (grant),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req       = 4'd0;
    out_ready = 1'b1;
    step(2);
    rst_n = 1'b1;
  endtask

  // One full transaction with out_ready high: selection edge, four grant
  // cycles, release cycle with done, then the idle arbitration cycle.
  task automatic expect_txn(input string tag, input logic [3:0] g, input logic [1:0] s);
    step(1);
    check({tag, "_sel"}, 32'(sel), 32'(s));
    check({tag, "_busy"}, 32'(busy), 32'd1);
    for (int c = 0; c < 4; c++) begin
      if (c > 0) step(1);
      check({tag, "_grant"}, 32'(grant), 32'(g));
      check({tag, "_nodone"}, 32'(done), 32'd0);
    end
    step(1);
    check({tag, "_rel_grant"}, 32'(grant), 32'd0);
    check({tag, "_rel_done"}, 32'(done), 32'(g));
    check({tag, "_rel_busy"}, 32'(busy), 32'd1);
    step(1);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_idle_done"}, 32'(done), 32'd0);
    check({tag, "_idle_grant"}, 32'(grant), 32'd0);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    req       = 4'd0;
    out_ready = 1'b1;

    // Reset state
    step(2);
    rst_n = 1'b1;
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    step(1);
    check("idle_noreq_grant", 32'(grant), 32'd0);

    // Single request from slot 2
    req = 4'b0100;
    step(1);
    check("single_sel", 32'(sel), 32'd2);
    for (int c = 0; c < 4; c++) begin
      if (c > 0) step(1);
      check("single_grant", 32'(grant), 32'b0100);
      check("single_busy", 32'(busy), 32'd1);
    end
    step(1);
    check("single_rel_grant", 32'(grant), 32'd0);
    check("single_rel_done", 32'(done), 32'b0100);
    req = 4'b0000;
    step(1);
    check("single_done_clr", 32'(done), 32'd0);
    check("single_busy_clr", 32'(busy), 32'd0);
    step(2);
    check("single_sel_hold", 32'(sel), 32'd2);
    check("single_idle_grant", 32'(grant), 32'd0);

`ifdef ARB_FIXED_PRIO_EN
    // Fixed priority: slot 0 always wins while requesting
    do_reset();
    req = 4'b1111;
    for (int t = 0; t < 3; t++) expect_txn("fix_all", 4'b0001, 2'd0);
    req = 4'b1100;
    for (int t = 0; t < 2; t++) expect_txn("fix_hi", 4'b0100, 2'd2);
    req = 4'b0000;
`else
    // Round-robin with all slots requesting, period 6
    do_reset();
    req = 4'b1111;
    expect_txn("rr0", 4'b0001, 2'd0);
    expect_txn("rr1", 4'b0010, 2'd1);
    expect_txn("rr2", 4'b0100, 2'd2);
    expect_txn("rr3", 4'b1000, 2'd3);
    expect_txn("rr4", 4'b0001, 2'd0);
    req = 4'b0000;
`endif

    // Backpressure: three stalled cycles stretch the grant to seven
    do_reset();
    req = 4'b0010;
    step(1);
    check("bp_g1", 32'(grant), 32'b0010);
    step(1);
    check("bp_g2", 32'(grant), 32'b0010);
    step(1);
    check("bp_g3", 32'(grant), 32'b0010);
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step(1);
      check("bp_stall_grant", 32'(grant), 32'b0010);
      check("bp_stall_done", 32'(done), 32'd0);
    end
    out_ready = 1'b1;
    step(1);
    check("bp_g7", 32'(grant), 32'b0010);
    check("bp_g7_done", 32'(done), 32'd0);
    step(1);
    check("bp_rel_grant", 32'(grant), 32'd0);
    check("bp_rel_done", 32'(done), 32'b0010);
    req = 4'b0000;
    step(2);

    // Abort: slot 0 withdraws on its second grant cycle
    do_reset();
    req = 4'b1001;
    step(1);
    check("ab_g1", 32'(grant), 32'b0001);
    check("ab_sel0", 32'(sel), 32'd0);
    step(1);
    check("ab_g2", 32'(grant), 32'b0001);
    req = 4'b1000;
    step(1);
    check("ab_grant_clr", 32'(grant), 32'd0);
    check("ab_busy_clr", 32'(busy), 32'd0);
    check("ab_no_done", 32'(done), 32'd0);
    step(1);
    check("ab_next_grant", 32'(grant), 32'b1000);
    check("ab_next_sel", 32'(sel), 32'd3);
    check("ab_next_done", 32'(done), 32'd0);
    req = 4'b0000;
    step(1);

    // Asynchronous reset in the middle of a dispense
    do_reset();
    req = 4'b0001;
    step(2);
    check("ar_pre_grant", 32'(grant), 32'b0001);
    check("ar_pre_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_grant", 32'(grant), 32'd0);
    check("ar_busy", 32'(busy), 32'd0);
    check("ar_sel", 32'(sel), 32'd0);
    check("ar_done", 32'(done), 32'd0);
    req = 4'b0000;
    step(1);
    rst_n = 1'b1;
    step(1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
